// File: rtl/tl_ul_pkg.sv
// TileLink-UL opcode constants and default widths shared by the memory responder.
// Shared by tl_ul_mem_responder and tl_ul_resp_fifo.
package tl_ul_pkg;

  localparam int unsigned TL_ADDR_WIDTH_DEF   = 64;
  localparam int unsigned TL_DATA_WIDTH_DEF   = 64;
  localparam int unsigned TL_SOURCE_WIDTH_DEF = 3;
  localparam int unsigned TL_SINK_WIDTH_DEF   = 3;
  localparam int unsigned TL_OPCODE_WIDTH_DEF = 3;
  localparam int unsigned TL_PARAM_WIDTH_DEF  = 3;
  localparam int unsigned TL_SIZE_WIDTH_DEF   = 8;

  localparam logic [2:0] TL_A_PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] TL_A_GET              = 3'd4;

  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

  // Only Get and the two Put flavours are serviced; everything else is an error.
  function automatic logic tl_a_is_put(input logic [2:0] op);
    return (op == TL_A_PUT_FULL_DATA) || (op == TL_A_PUT_PARTIAL_DATA);
  endfunction

endpackage

// File: rtl/tl_ul_resp_fifo.sv
// Two-entry response queue; head is zero whenever the queue is empty.
// Push is ignored when full, pop is ignored when empty; both may happen together.
module tl_ul_resp_fifo
  import tl_ul_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] entry_q [2];
  logic [WIDTH-1:0] entry_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : entry_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + 2'(do_push) - 2'(do_pop);
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    assign entry_d[gi] = (do_push && (wr_ptr_q == 1'(gi))) ? push_data : entry_q[gi];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) entry_q[gi] <= '0;
      else     entry_q[gi] <= entry_d[gi];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/tl_ul_mem_responder.sv
// TileLink-UL memory slave: single-cycle Get/Put against a word array, 2-deep D queue.
// Define TL_UL_RESP_ERR_CHECK_EN to flag out-of-range, oversized and misaligned beats.
module tl_ul_mem_responder
  import tl_ul_pkg::*;
#(
  parameter int unsigned TL_ADDR_WIDTH   = TL_ADDR_WIDTH_DEF,
  parameter int unsigned TL_DATA_WIDTH   = TL_DATA_WIDTH_DEF,
  parameter int unsigned TL_SOURCE_WIDTH = TL_SOURCE_WIDTH_DEF,
  parameter int unsigned TL_SINK_WIDTH   = TL_SINK_WIDTH_DEF,
  parameter int unsigned TL_OPCODE_WIDTH = TL_OPCODE_WIDTH_DEF,
  parameter int unsigned TL_PARAM_WIDTH  = TL_PARAM_WIDTH_DEF,
  parameter int unsigned TL_SIZE_WIDTH   = TL_SIZE_WIDTH_DEF,
  parameter logic [63:0] MEM_BASE_ADDR   = 64'h0,
  parameter int unsigned DEPTH           = 512
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [TL_OPCODE_WIDTH-1:0]   a_opcode,
  input  logic [TL_PARAM_WIDTH-1:0]    a_param,
  input  logic [TL_ADDR_WIDTH-1:0]     a_address,
  input  logic [TL_SIZE_WIDTH-1:0]     a_size,
  input  logic [TL_DATA_WIDTH/8-1:0]   a_mask,
  input  logic [TL_DATA_WIDTH-1:0]     a_data,
  input  logic [TL_SOURCE_WIDTH-1:0]   a_source,
  output logic                         d_valid,
  input  logic                         d_ready,
  output logic [TL_OPCODE_WIDTH-1:0]   d_opcode,
  output logic [TL_PARAM_WIDTH-1:0]    d_param,
  output logic [TL_SIZE_WIDTH-1:0]     d_size,
  output logic [TL_SINK_WIDTH-1:0]     d_sink,
  output logic [TL_SOURCE_WIDTH-1:0]   d_source,
  output logic [TL_DATA_WIDTH-1:0]     d_data,
  output logic                         d_error
);

  localparam int unsigned TL_STRB_WIDTH = TL_DATA_WIDTH / 8;
  localparam int unsigned OFF_W   = (TL_STRB_WIDTH > 1) ? $clog2(TL_STRB_WIDTH) : 0;
  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ENTRY_W = TL_OPCODE_WIDTH + 1 + TL_SIZE_WIDTH + TL_SOURCE_WIDTH
                                    + TL_DATA_WIDTH;
  localparam logic [TL_ADDR_WIDTH-1:0] BASE = TL_ADDR_WIDTH'(MEM_BASE_ADDR);

  logic [TL_DATA_WIDTH-1:0]   mem [DEPTH];

  logic                       accept, pop, full, empty;
  logic                       is_get, is_put, bad_op, addr_err, err, wr_en;
  logic [TL_ADDR_WIDTH-1:0]   word_addr;
  logic [IDX_W-1:0]           idx;
  logic [TL_OPCODE_WIDTH-1:0] resp_op;
  logic [TL_DATA_WIDTH-1:0]   resp_data;
  logic [ENTRY_W-1:0]         push_entry, head_entry;
  logic                       unused_param;

  assign a_ready = !full;
  assign accept  = a_valid && a_ready;
  assign d_valid = !empty;
  assign pop     = d_valid && d_ready;

  assign unused_param = ^a_param;

`ifdef TL_UL_RESP_ERR_CHECK_EN
  logic [TL_ADDR_WIDTH-1:0] offset;
  logic [TL_ADDR_WIDTH-1:0] align_mask;

  // An address below the base wraps to a huge offset and fails the range test.
  always_comb begin
    offset     = a_address - BASE;
    align_mask = (TL_ADDR_WIDTH'(1) << a_size) - TL_ADDR_WIDTH'(1);
    addr_err   = (offset >= TL_ADDR_WIDTH'(DEPTH * TL_STRB_WIDTH))
              || (a_size > TL_SIZE_WIDTH'(OFF_W))
              || ((a_address & align_mask) != '0);
  end
`else
  assign addr_err = 1'b0;
`endif

  always_comb begin
    word_addr = (a_address - BASE) >> OFF_W;
    idx       = IDX_W'(word_addr % TL_ADDR_WIDTH'(DEPTH));
    is_get    = (a_opcode == TL_OPCODE_WIDTH'(TL_A_GET));
    is_put    = (a_opcode == TL_OPCODE_WIDTH'(TL_A_PUT_FULL_DATA))
             || (a_opcode == TL_OPCODE_WIDTH'(TL_A_PUT_PARTIAL_DATA));
    bad_op    = !(is_get || is_put);
    err       = bad_op || addr_err;
    // Reset wins over a beat presented on the same edge: nothing is written.
    wr_en     = accept && is_put && !err && !rst;
    resp_op   = is_get ? TL_OPCODE_WIDTH'(TL_D_ACCESS_ACK_DATA)
                       : TL_OPCODE_WIDTH'(TL_D_ACCESS_ACK);
    resp_data = (is_get && !err) ? mem[idx] : '0;
    push_entry = {resp_op, err, a_size, a_source, resp_data};
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < TL_STRB_WIDTH; b++) begin
        if (a_mask[b]) mem[idx][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

  tl_ul_resp_fifo #(
    .WIDTH (ENTRY_W)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head_entry)
  );

  assign {d_opcode, d_error, d_size, d_source, d_data} = head_entry;
  assign d_param = '0;
  assign d_sink  = '0;

endmodule

// File: tb/tb_tl_ul_mem_responder.sv
// Randomised bench for tl_ul_mem_responder against a queue/array reference model.
// Honours TL_UL_RESP_ERR_CHECK_EN when the design is built with it.
module tb_tl_ul_mem_responder;

  localparam int DEPTH = 512;

  typedef struct {
    logic [2:0]  op;
    logic        err;
    logic [7:0]  size;
    logic [2:0]  src;
    logic [63:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [63:0] a_address;
  logic [7:0]  a_size;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic [2:0]  a_source;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [7:0]  d_size;
  logic [2:0]  d_sink;
  logic [2:0]  d_source;
  logic [63:0] d_data;
  logic        d_error;

  int          n_checks = 0;
  int          n_fail   = 0;
  resp_t       exp_q[$];
  logic [63:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  tl_ul_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_opcode  (a_opcode),
    .a_param   (a_param),
    .a_address (a_address),
    .a_size    (a_size),
    .a_mask    (a_mask),
    .a_data    (a_data),
    .a_source  (a_source),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_opcode  (d_opcode),
    .d_param   (d_param),
    .d_size    (d_size),
    .d_sink    (d_sink),
    .d_source  (d_source),
    .d_data    (d_data),
    .d_error   (d_error)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one accepted A beat: returns the response, updates model memory.
  task automatic model_access(input logic [2:0] op, input logic [63:0] addr,
                              input logic [7:0] sz, input logic [7:0] msk,
                              input logic [63:0] dat, input logic [2:0] src,
                              output resp_t r);
    int   widx;
    logic is_get, is_put, e;
    widx   = int'((addr / 64'd8) % 64'(DEPTH));
    is_get = (op == 3'd4);
    is_put = (op == 3'd0) || (op == 3'd1);
    e      = !(is_get || is_put);
`ifdef TL_UL_RESP_ERR_CHECK_EN
    if (addr >= 64'(DEPTH * 8) || sz > 8'd3 || (addr % (64'd1 << sz)) != 64'd0) e = 1'b1;
`endif
    r.op   = is_get ? 3'd1 : 3'd0;
    r.err  = e;
    r.size = sz;
    r.src  = src;
    r.data = (is_get && !e) ? model_mem[widx] : 64'd0;
    if (is_put && !e) begin
      for (int b = 0; b < 8; b++) begin
        if (msk[b]) model_mem[widx][8*b +: 8] = dat[8*b +: 8];
      end
    end
  endtask

  // One clock: check outputs against the model, drive a beat, advance model and clock.
  task automatic step(input logic av, input logic [2:0] op, input logic [63:0] addr,
                      input logic [7:0] sz, input logic [7:0] msk, input logic [63:0] dat,
                      input logic [2:0] src, input logic dr, output logic accepted);
    resp_t h, r;
    logic  pop;
    check_val("a_ready", {63'd0, a_ready}, {63'd0, exp_q.size() < 2});
    check_val("d_valid", {63'd0, d_valid}, {63'd0, exp_q.size() > 0});
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      check_val("d_opcode", 64'(d_opcode), 64'(h.op));
      check_val("d_error",  64'(d_error),  64'(h.err));
      check_val("d_size",   64'(d_size),   64'(h.size));
      check_val("d_source", 64'(d_source), 64'(h.src));
      check_val("d_data",   d_data,        h.data);
      check_val("d_param",  64'(d_param),  64'd0);
      check_val("d_sink",   64'(d_sink),   64'd0);
    end
    a_valid   = av;
    a_opcode  = op;
    a_param   = 3'($urandom_range(0, 7));
    a_address = addr;
    a_size    = sz;
    a_mask    = msk;
    a_data    = dat;
    a_source  = src;
    d_ready   = dr;
    accepted  = av && (exp_q.size() < 2);
    pop       = (exp_q.size() > 0) && dr;
    if (pop) begin
      h = exp_q.pop_front();
      $display("txn src=%0d op=%0d err=%0b size=%0d data=%h", h.src, h.op, h.err, h.size, h.data);
    end
    if (accepted) begin
      model_access(op, addr, sz, msk, dat, src, r);
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic dr);
    logic acc;
    step(1'b0, 3'd4, 64'd0, 8'd3, 8'hFF, 64'd0, 3'd0, dr, acc);
  endtask

  initial begin
    logic        acc;
    logic [2:0]  op;
    logic [63:0] addr;
    logic [7:0]  sz, msk;
    int          sel;

    rst = 1'b1;
    a_valid = 1'b0; a_opcode = 3'd0; a_param = 3'd0; a_address = 64'd0;
    a_size = 8'd0; a_mask = 8'd0; a_data = 64'd0; a_source = 3'd0; d_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_a_ready",  64'(a_ready),  64'd1);
    check_val("rst_d_valid",  64'(d_valid),  64'd0);
    check_val("rst_d_opcode", 64'(d_opcode), 64'd0);
    check_val("rst_d_data",   d_data,        64'd0);
    check_val("rst_d_error",  64'(d_error),  64'd0);
    check_val("rst_d_source", 64'(d_source), 64'd0);
    check_val("rst_d_size",   64'(d_size),   64'd0);
    rst = 1'b0;

    // Give the words used below known contents.
    for (int w = 0; w < 16; w++) begin
      step(1'b1, 3'd0, 64'(w * 8), 8'd3, 8'hFF, {$urandom, $urandom}, 3'(w), 1'b1, acc);
    end
    idle(1'b1);
    idle(1'b1);

    // PutFullData, then Get of the same word, then partial write and Get.
    step(1'b1, 3'd0, 64'h10, 8'd3, 8'hFF, 64'hDEADBEEF_CAFEF00D, 3'd2, 1'b1, acc);
    check_val("put_full_d_valid",  64'(d_valid),  64'd1);
    check_val("put_full_d_source", 64'(d_source), 64'd2);
    step(1'b1, 3'd4, 64'h10, 8'd3, 8'hFF, 64'd0, 3'd3, 1'b1, acc);
    check_val("get_after_put_data", d_data, 64'hDEADBEEF_CAFEF00D);
    step(1'b1, 3'd1, 64'h10, 8'd3, 8'h0F, 64'h11111111_22222222, 3'd4, 1'b1, acc);
    step(1'b1, 3'd4, 64'h10, 8'd3, 8'hFF, 64'd0, 3'd5, 1'b1, acc);
    check_val("get_after_partial_data", d_data, 64'hDEADBEEF_22222222);
    idle(1'b1);

    // Back-pressure: two Gets fill the queue, the third waits until a pop.
    step(1'b1, 3'd4, 64'h00, 8'd3, 8'hFF, 64'd0, 3'd1, 1'b0, acc);
    step(1'b1, 3'd4, 64'h08, 8'd3, 8'hFF, 64'd0, 3'd2, 1'b0, acc);
    step(1'b1, 3'd4, 64'h10, 8'd3, 8'hFF, 64'd0, 3'd3, 1'b0, acc);
    check_val("third_get_blocked", 64'(acc), 64'd0);
    acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++) begin
      step(1'b1, 3'd4, 64'h10, 8'd3, 8'hFF, 64'd0, 3'd3, 1'b1, acc);
    end
    check_val("third_get_accepted", 64'(acc), 64'd1);
    idle(1'b1);
    idle(1'b1);

    // Unsupported opcode and a Get one word past the end of memory.
    step(1'b1, 3'd6, 64'h18, 8'd3, 8'hFF, 64'h1234, 3'd6, 1'b1, acc);
    check_val("opcode6_d_error",  64'(d_error),  64'd1);
    check_val("opcode6_d_opcode", 64'(d_opcode), 64'd0);
    step(1'b1, 3'd4, 64'(DEPTH * 8), 8'd3, 8'hFF, 64'd0, 3'd7, 1'b1, acc);
    idle(1'b1);

    // Reset with two responses queued and a Put presented across the reset edge.
    step(1'b1, 3'd4, 64'h20, 8'd3, 8'hFF, 64'd0, 3'd1, 1'b0, acc);
    step(1'b1, 3'd4, 64'h28, 8'd3, 8'hFF, 64'd0, 3'd2, 1'b0, acc);
    a_valid = 1'b1; a_opcode = 3'd0; a_address = 64'h18; a_mask = 8'hFF;
    a_data = 64'hBAD0_BAD0_BAD0_BAD0; a_size = 8'd3;
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_d_valid", 64'(d_valid), 64'd0);
    check_val("async_rst_a_ready", 64'(a_ready), 64'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_valid = 1'b0;
    step(1'b1, 3'd4, 64'h18, 8'd3, 8'hFF, 64'd0, 3'd3, 1'b1, acc);
    step(1'b1, 3'd4, 64'h10, 8'd3, 8'hFF, 64'd0, 3'd4, 1'b1, acc);
    idle(1'b1);

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      sel = int'($urandom_range(0, 9));
      op  = (sel < 4) ? 3'd4 : (sel < 6) ? 3'd0 : (sel < 8) ? 3'd1
                      : 3'($urandom_range(2, 7));
      if (op == 3'd4) op = 3'd4;
      else if (op == 3'd4 - 3'd0) op = 3'd5;
      sz   = ($urandom_range(0, 15) == 0) ? 8'd4 : 8'($urandom_range(0, 3));
      addr = 64'($urandom_range(0, 15)) * 64'd8;
      if (sz <= 8'd3) addr = addr + 64'($urandom_range(0, (8 >> sz) - 1)) * (64'd1 << sz);
      if ($urandom_range(0, 15) == 0) addr = addr + 64'd1;
      if ($urandom_range(0, 7) == 0)  addr = addr + 64'(DEPTH * 8) * 64'($urandom_range(1, 3));
      msk  = (op == 3'd0) ? 8'hFF : 8'($urandom_range(0, 255));
      step($urandom_range(0, 9) < 7, op, addr, sz, msk, {$urandom, $urandom},
           3'($urandom_range(0, 7)), $urandom_range(0, 9) < 7, acc);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_ul_mem_responder.md
TL_UL_MEM_RESPONDER -- requirements
Module: tl_ul_mem_responder

Interface
REQ-001 Parameter TL_ADDR_WIDTH, default 64: A-channel address width.
REQ-002 Parameter TL_DATA_WIDTH, default 64: data width; TL_STRB_WIDTH = TL_DATA_WIDTH/8.
REQ-003 Parameters TL_SOURCE_WIDTH, TL_SINK_WIDTH, TL_OPCODE_WIDTH, TL_PARAM_WIDTH, default 3 each; TL_SIZE_WIDTH, default 8.
REQ-004 Parameter MEM_BASE_ADDR, default 64'h0: byte address of word 0.
REQ-005 Parameter DEPTH, default 512: number of TL_DATA_WIDTH words.
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 a_valid in 1, a_ready out 1: A-channel handshake.
REQ-009 a_opcode, a_param, a_address, a_size, a_mask, a_data, a_source: inputs at the widths above.
REQ-010 d_valid out 1, d_ready in 1: D-channel handshake.
REQ-011 d_opcode, d_param, d_size, d_sink, d_source, d_data, d_error: outputs at the widths above (d_error 1 bit).

Function
REQ-012 A beat accepted on rising edge where a_valid && a_ready; a_ready = (queue count < 2), combinational from state only.
REQ-013 Response queue: 2 entries, FIFO order; push on A accept, pop on d_valid && d_ready; push and pop in the same cycle both take effect.
REQ-014 d_valid = queue not empty; D fields driven from head entry; head held stable while d_valid && !d_ready.
REQ-015 Latency: beat accepted in cycle N yields d_valid in cycle N+1 when queue was empty.
REQ-016 Get (4): d_opcode = AccessAckData (1), d_data = word at index (a_address - MEM_BASE_ADDR) >> log2(TL_STRB_WIDTH), read at accept.
REQ-017 PutFullData (0) and PutPartialData (1): bytes with a_mask bit set written at accept edge; d_opcode = AccessAck (0), d_data = 0.
REQ-018 Read-after-write: Get accepted the cycle after a Put to the same word returns the new data.
REQ-019 d_param = 0, d_sink = 0; d_size and d_source echo the accepted beat.
REQ-020 Opcodes 2,3,5,6,7 unsupported: d_opcode = AccessAck (0), d_error = 1, no memory change.
REQ-021 Queue full (count 2) with a_valid high: a_ready = 0, no state change; with simultaneous pop a_ready stays 0 that cycle.

Reset
REQ-022 On rst: queue empty, a_ready = 1, d_valid = 0, all D fields 0; memory contents not reset.
REQ-023 rst asserted mid-transaction discards queued responses; no partial memory write on the reset edge.

Configuration
REQ-024 Macro TL_UL_RESP_ERR_CHECK_EN defined: address outside [MEM_BASE_ADDR, MEM_BASE_ADDR + DEPTH*TL_STRB_WIDTH), a_size > log2(TL_STRB_WIDTH), or address misaligned to 2^a_size gives d_error = 1, no write, d_data = 0, opcode per REQ-016/017.
REQ-025 Macro undefined: only REQ-020 errors generated; word index taken modulo DEPTH; d_error = 0 for Get/Put.

Structure
REQ-026 Package tl_ul_pkg holds the A/D opcode constants and default width constants; the module imports it.
REQ-027 One sub-module tl_ul_resp_fifo: 2-entry response queue (push, pop, full, empty, head outputs).

Verification
REQ-028 PutFullData addr 0x10, mask 0xFF, data 0xDEADBEEF_CAFEF00D, source 2 -> next cycle d_valid, d_opcode 0, d_source 2, d_error 0.
REQ-029 Get addr 0x10 after REQ-028 -> d_opcode 1, d_data 0xDEADBEEF_CAFEF00D.
REQ-030 PutPartialData addr 0x10, mask 0x0F, data 0x11111111_22222222 then Get -> d_data 0xDEADBEEF_22222222.
REQ-031 d_ready held 0, three back-to-back Gets -> two accepted, a_ready 0 on third; release d_ready -> responses in order, third accepted.
REQ-032 Opcode 6 -> d_opcode 0, d_error 1; with TL_UL_RESP_ERR_CHECK_EN, Get addr DEPTH*8 -> d_error 1, d_data 0.
REQ-033 rst pulsed with two responses queued -> d_valid 0, a_ready 1 asynchronously; following Get returns memory contents intact.
